// File: rtl/dmem_lsu_ram.sv
// dmem_lsu_ram: byte-lane data RAM behind a valid/ready LSU port with funct3 size decode and load extension.
// Optional `define DMEM_MISALIGN_TRAP_EN turns misaligned accesses into errors instead of aligning them down.
module dmem_lsu_ram #(
    parameter int          DATA_W    = 32,
    parameter int          ADDR_W    = 12,
    parameter logic [31:0] BASE_ADDR = 32'h0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [31:0]       req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err
);
    localparam int LANES = DATA_W / 8;
    localparam int OFF_W = $clog2(LANES);
    localparam int DEPTH = (1 << ADDR_W) / LANES;

    typedef enum logic [1:0] {IDLE, LOAD, RESP} state_t;

    state_t                  state, nxt;
    logic                    acc, legal, in_region, acc_err, err_q;
    logic [OFF_W-1:0]        off, amask, eff_off, off_q;
    logic [LANES-1:0]        be;
    logic [DATA_W-1:0]       wsh, rd_q, sh, ext;
    logic [ADDR_W-OFF_W-1:0] idx;
    logic [2:0]              f3_q;

    assign req_ready = state == IDLE;
    assign rsp_valid = state == RESP;
    assign acc       = req_valid & req_ready;

    always_comb begin
        amask     = OFF_W'({req_funct3[1] & req_funct3[0], req_funct3[1], |req_funct3[1:0]});
        legal     = req_funct3 != 3'b111 && (DATA_W == 64 || (req_funct3 != 3'b011 && req_funct3 != 3'b110));
        in_region = req_addr[31:ADDR_W] == BASE_ADDR[31:ADDR_W];
        off       = req_addr[OFF_W-1:0];
`ifdef DMEM_MISALIGN_TRAP_EN
        acc_err   = !legal || !in_region || |(off & amask);
        eff_off   = off;
`else
        acc_err   = !legal || !in_region;
        eff_off   = off & ~amask;
`endif
        idx       = req_addr[ADDR_W-1:OFF_W];
        be        = LANES'(req_funct3[1:0] == 2'd0 ? 8'h01 :
                           req_funct3[1:0] == 2'd1 ? 8'h03 :
                           req_funct3[1:0] == 2'd2 ? 8'h0F : 8'hFF) << eff_off;
        wsh       = req_wdata << {eff_off, 3'b000};
        sh        = rd_q >> {off_q, 3'b000};
        ext       = f3_q == 3'b000 ? DATA_W'($signed(sh[7:0]))  :
                    f3_q == 3'b001 ? DATA_W'($signed(sh[15:0])) :
                    f3_q == 3'b010 ? DATA_W'($signed(sh[31:0])) :
                    f3_q == 3'b100 ? DATA_W'(sh[7:0])           :
                    f3_q == 3'b101 ? DATA_W'(sh[15:0])          :
                    f3_q == 3'b110 ? DATA_W'(sh[31:0])          : sh;
    end

    // Banks are never reset; every lane is read on a load so the LOAD cycle can pick lanes.
    for (genvar i = 0; i < LANES; i++) begin : g_lane
        logic [7:0] mem [DEPTH];
        logic [7:0] rd;
        always_ff @(posedge clk) begin
            if (acc && req_we && !acc_err && be[i])
                mem[idx] <= wsh[8*i +: 8];
            if (acc && !req_we)
                rd <= mem[idx];
        end
        assign rd_q[8*i +: 8] = rd;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= nxt;
    end

    always_comb begin
        nxt = state;
        nxt = state == IDLE ? (acc ? (req_we ? RESP : LOAD) : IDLE) :
              state == LOAD ? RESP : (rsp_ready ? IDLE : RESP);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            off_q     <= '0;
            f3_q      <= '0;
            err_q     <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else if (acc) begin
            off_q     <= eff_off;
            f3_q      <= req_funct3;
            err_q     <= acc_err;
            rsp_rdata <= '0;
            rsp_err   <= req_we & acc_err;
        end else if (state == LOAD) begin
            rsp_rdata <= err_q ? '0 : ext;
            rsp_err   <= err_q;
        end
    end
endmodule
